// File: rtl/sparam_sweep_ctrl.sv
// Frequency/port sweep sequencer feeding the S-parameter measurement stage.
// Optional measurement timeout enabled by defining SWEEP_TIMEOUT_EN.
module sparam_sweep_ctrl #(
    parameter int NPORTS  = 4,
    parameter int FW      = 32,
    parameter int PW      = 16,
    parameter int DW      = 32,
    parameter int SW      = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [FW-1:0] f_start,
    input  logic [FW-1:0] f_step,
    input  logic [PW-1:0] n_points,
    input  logic [SW-1:0] settle_cycles,
    output logic [FW-1:0] f_word,
    output logic [3:0]    port_sel,
    output logic          src_en,
    output logic          meas_req,
    input  logic          meas_ack,
    input  logic [DW-1:0] meas_data,
    output logic          rec_valid,
    input  logic          rec_ready,
    output logic [DW-1:0] rec_data,
    output logic [PW-1:0] rec_point,
    output logic [3:0]    rec_port,
    output logic          rec_err,
    output logic          busy,
    output logic          done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_MEASURE = 3'd2;
    localparam logic [2:0] S_EMIT    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    if (NPORTS < 2 || NPORTS > 15 || TIMEOUT < 1) begin : g_bad_cfg
        $error("sparam_sweep_ctrl: NPORTS must be 2..15 and TIMEOUT at least 1");
    end

    logic [2:0]    state;
    logic [FW-1:0] f_step_q;
    logic [PW-1:0] n_pts_q;
    logic [PW-1:0] point;
    logic [SW-1:0] settle_cnt;
    logic          last_port;
    logic          last_point;

    assign last_port  = (port_sel == 4'(NPORTS));
    assign last_point = (point == n_pts_q - PW'(1));

    // Control outputs decode straight from the state so abort and reset clear them together.
    assign busy      = (state != S_IDLE);
    assign src_en    = (state == S_SETTLE) || (state == S_MEASURE) || (state == S_EMIT);
    assign meas_req  = (state == S_MEASURE);
    assign rec_valid = (state == S_EMIT);
    assign done      = (state == S_DONE);

`ifdef SWEEP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));
`else
    assign rec_err = 1'b0;
`endif

    // NOTE: every register below is updated with non-blocking assignments so all
    // branches see the pre-edge values; the reset arm is asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            f_step_q   <= '0;
            n_pts_q    <= '0;
            point      <= '0;
            settle_cnt <= '0;
            f_word     <= '0;
            port_sel   <= '0;
            rec_data   <= '0;
            rec_point  <= '0;
            rec_port   <= '0;
`ifdef SWEEP_TIMEOUT_EN
            tmo_cnt    <= '0;
            rec_err    <= 1'b0;
`endif
        end else if (abort) begin
            // A pending record is dropped and the outputs return to their idle values.
            state      <= S_IDLE;
            point      <= '0;
            settle_cnt <= '0;
            f_word     <= '0;
            port_sel   <= '0;
            rec_data   <= '0;
            rec_point  <= '0;
            rec_port   <= '0;
`ifdef SWEEP_TIMEOUT_EN
            tmo_cnt    <= '0;
            rec_err    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (n_points != '0) begin
                            f_step_q   <= f_step;
                            n_pts_q    <= n_points;
                            f_word     <= f_start;
                            port_sel   <= 4'd1;
                            point      <= '0;
                            settle_cnt <= settle_cycles;
                            state      <= S_SETTLE;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= S_MEASURE;
`ifdef SWEEP_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end else begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end
                S_MEASURE: begin
                    if (meas_ack) begin
                        rec_data  <= meas_data;
                        rec_point <= point;
                        rec_port  <= port_sel;
                        state     <= S_EMIT;
`ifdef SWEEP_TIMEOUT_EN
                        rec_err   <= 1'b0;
                    end else if (tmo_hit) begin
                        rec_data  <= '0;
                        rec_point <= point;
                        rec_port  <= port_sel;
                        rec_err   <= 1'b1;
                        state     <= S_EMIT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
`endif
                    end
                end
                S_EMIT: begin
                    if (rec_ready) begin
                        settle_cnt <= settle_cycles;
                        if (!last_port) begin
                            port_sel <= port_sel + 4'd1;
                            state    <= S_SETTLE;
                        end else if (last_point) begin
                            state <= S_DONE;
                        end else begin
                            // Frequency word wraps silently modulo 2^FW.
                            port_sel <= 4'd1;
                            point    <= point + PW'(1);
                            f_word   <= f_word + f_step_q;
                            state    <= S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    port_sel <= '0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sparam_sweep_ctrl.sv
// Directed testbench for sparam_sweep_ctrl (NPORTS=4, TIMEOUT=16).
// Cycle numbers below count rising edges after the edge that sampled start.
module tb_sparam_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] f_start = '0;
    logic [31:0] f_step = '0;
    logic [15:0] n_points = '0;
    logic [15:0] settle_cycles = '0;
    logic [31:0] f_word;
    logic [3:0]  port_sel;
    logic        src_en;
    logic        meas_req;
    logic        meas_ack = 1'b0;
    logic [31:0] meas_data = '0;
    logic        rec_valid;
    logic        rec_ready = 1'b1;
    logic [31:0] rec_data;
    logic [15:0] rec_point;
    logic [3:0]  rec_port;
    logic        rec_err;
    logic        busy;
    logic        done;

    sparam_sweep_ctrl #(
        .NPORTS(4), .FW(32), .PW(16), .DW(32), .SW(16), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .f_start(f_start), .f_step(f_step), .n_points(n_points),
        .settle_cycles(settle_cycles), .f_word(f_word), .port_sel(port_sel),
        .src_en(src_en), .meas_req(meas_req), .meas_ack(meas_ack),
        .meas_data(meas_data), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_data(rec_data), .rec_point(rec_point), .rec_port(rec_port),
        .rec_err(rec_err), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Results of the most recent sweep.
    int          rec_cnt, first_req_cyc, done_cnt, done_cyc, hs_cyc;
    int          src_viol, bp_viol, bp_cycles;
    bit          timed_out, aborted;
    logic        post_busy;
    logic [3:0]  post_port_sel;
    logic [3:0]  log_port [32];
    logic [15:0] log_point [32];
    logic [31:0] log_data [32];
    logic [31:0] log_fword [32];
    logic        log_err [32];
    int          log_req_len [32];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one sweep acting as measurement source and record sink.
    task automatic run_sweep(input logic [15:0] np, input logic [31:0] fs, input logic [31:0] fst,
                             input logic [15:0] sc, input int ack_delay, input int bp_idx,
                             input int noack_idx, input int abort_at, input bit spam);
        bit          prev_req, done_seen, bp_started, fin;
        int          bp_left, req_age, cur_req_len, cyc;
        logic [31:0] snap_data;
        logic [15:0] snap_point;
        logic [3:0]  snap_port;
        prev_req = 0; done_seen = 0; bp_started = 0; fin = 0;
        bp_left = 0; req_age = 0; cur_req_len = 0;
        snap_data = '0; snap_point = '0; snap_port = '0;
        rec_cnt = 0; first_req_cyc = -1; done_cnt = 0; done_cyc = -1; hs_cyc = -1;
        src_viol = 0; bp_viol = 0; bp_cycles = 0; timed_out = 0; aborted = 0;
        post_busy = 1'bx; post_port_sel = 4'hx;
        f_start = fs; f_step = fst; n_points = np; settle_cycles = sc;
        rec_ready = 1'b1; meas_ack = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!fin) begin
            if (cyc >= 2000) begin
                timed_out = 1;
                fin = 1;
            end else if (done_seen) begin
                post_busy = busy;
                post_port_sel = port_sel;
                if (done) done_cnt++;
                fin = 1;
            end else begin
                if (done) begin
                    done_cnt++;
                    done_seen = 1;
                    done_cyc = cyc;
                    if (src_en) src_viol++;
                end else if (busy && !src_en) begin
                    src_viol++;
                end
                if (meas_req && first_req_cyc < 0) first_req_cyc = cyc;
                if (abort_at >= 0 && meas_req && rec_cnt == abort_at) begin
                    aborted = 1;
                    abort = 1'b1;
                    meas_ack = 1'b0;
                    fin = 1;
                end else begin
                    meas_ack = 1'b0;
                    meas_data = 32'hBAD0_0000 + 32'(rec_cnt);
                    if (meas_req) begin
                        if (!prev_req) begin
                            req_age = 0;
                            cur_req_len = 0;
                        end else begin
                            req_age++;
                        end
                        cur_req_len++;
                        if (req_age == ack_delay && rec_cnt != noack_idx) begin
                            meas_ack = 1'b1;
                            meas_data = 32'hD000_0000 + 32'(rec_cnt);
                        end
                    end
                    prev_req = meas_req;
                    if (bp_left > 0) begin
                        if (!rec_valid || meas_req || rec_data !== snap_data ||
                            rec_point !== snap_point || rec_port !== snap_port)
                            bp_viol++;
                        bp_cycles++;
                        bp_left--;
                        if (bp_left == 0) rec_ready = 1'b1;
                    end else if (rec_valid && rec_cnt == bp_idx && !bp_started) begin
                        bp_started = 1;
                        snap_data = rec_data;
                        snap_point = rec_point;
                        snap_port = rec_port;
                        bp_left = 10;
                        rec_ready = 1'b0;
                    end
                    if (rec_valid && rec_ready && rec_cnt < 32) begin
                        log_port[rec_cnt] = rec_port;
                        log_point[rec_cnt] = rec_point;
                        log_data[rec_cnt] = rec_data;
                        log_fword[rec_cnt] = f_word;
                        log_err[rec_cnt] = rec_err;
                        log_req_len[rec_cnt] = cur_req_len;
                        hs_cyc = cyc;
                        rec_cnt++;
                    end
                    if (spam) start = busy && !done;
                end
            end
            if (!fin) begin
                tick();
                cyc++;
            end
        end
        meas_ack = 1'b0;
        start = 1'b0;
        rec_ready = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({f_word, port_sel, src_en, meas_req, rec_valid, rec_data, rec_point, rec_port,
             rec_err, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%0b port_sel=%0d f_word=%0h, expected all zero",
                     busy, port_sel, f_word);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        run_sweep(16'd2, 32'd1000, 32'd500, 16'd3, 2, -1, -1, -1, 1'b0);
        n_checks++;
        if (timed_out || rec_cnt !== 8) begin
            n_fail++;
            $display("FAIL basic_count: got %0d records (timeout=%0b), expected 8", rec_cnt, timed_out);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (log_port[i] !== 4'(i % 4 + 1)) begin
                n_fail++;
                $display("FAIL basic_port[%0d]: got %0d, expected %0d", i, log_port[i], i % 4 + 1);
            end
            n_checks++;
            if (log_point[i] !== 16'(i / 4)) begin
                n_fail++;
                $display("FAIL basic_point[%0d]: got %0d, expected %0d", i, log_point[i], i / 4);
            end
            n_checks++;
            if (log_fword[i] !== 32'(1000 + 500 * (i / 4))) begin
                n_fail++;
                $display("FAIL basic_fword[%0d]: got %0d, expected %0d", i, log_fword[i], 1000 + 500 * (i / 4));
            end
            n_checks++;
            if (log_data[i] !== 32'hD000_0000 + 32'(i) || log_err[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_data[%0d]: got %0h err=%0b, expected %0h err=0",
                         i, log_data[i], log_err[i], 32'hD000_0000 + 32'(i));
            end
            n_checks++;
            if (log_req_len[i] !== 3) begin
                n_fail++;
                $display("FAIL basic_req_len[%0d]: got %0d, expected 3", i, log_req_len[i]);
            end
        end
        n_checks++;
        if (done_cnt !== 1 || done_cyc !== hs_cyc + 1) begin
            n_fail++;
            $display("FAIL basic_done: got %0d pulses at cycle %0d, expected 1 at cycle %0d",
                     done_cnt, done_cyc, hs_cyc + 1);
        end
        n_checks++;
        if (post_busy !== 1'b0 || post_port_sel !== 4'd0) begin
            n_fail++;
            $display("FAIL basic_idle: got busy=%0b port_sel=%0d, expected busy=0 port_sel=0",
                     post_busy, post_port_sel);
        end
        n_checks++;
        if (src_viol !== 0) begin
            n_fail++;
            $display("FAIL basic_src_en: got %0d bad cycles, expected 0", src_viol);
        end
    endtask

    task automatic test_settle();
        run_sweep(16'd1, 32'd50, 32'd0, 16'd0, 0, -1, -1, -1, 1'b0);
        n_checks++;
        if (first_req_cyc !== 1 || rec_cnt !== 4) begin
            n_fail++;
            $display("FAIL settle0: got first req at %0d (%0d records), expected 1 (4 records)",
                     first_req_cyc, rec_cnt);
        end
        run_sweep(16'd1, 32'd50, 32'd0, 16'd5, 1, -1, -1, -1, 1'b0);
        n_checks++;
        if (first_req_cyc !== 6 || rec_cnt !== 4) begin
            n_fail++;
            $display("FAIL settle5: got first req at %0d (%0d records), expected 6 (4 records)",
                     first_req_cyc, rec_cnt);
        end
    endtask

    task automatic test_backpressure();
        run_sweep(16'd1, 32'd77, 32'd1, 16'd2, 1, 2, -1, -1, 1'b0);
        n_checks++;
        if (bp_viol !== 0 || bp_cycles !== 10) begin
            n_fail++;
            $display("FAIL bp_stable: got %0d unstable of %0d held cycles, expected 0 of 10",
                     bp_viol, bp_cycles);
        end
        n_checks++;
        if (rec_cnt !== 4 || log_port[2] !== 4'd3 || log_data[2] !== 32'hD000_0002) begin
            n_fail++;
            $display("FAIL bp_record: got %0d records port=%0d data=%0h, expected 4 port=3 data=d0000002",
                     rec_cnt, log_port[2], log_data[2]);
        end
        n_checks++;
        if (log_port[3] !== 4'd4 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL bp_finish: got last port=%0d done=%0d, expected 4 and 1", log_port[3], done_cnt);
        end
    endtask

    task automatic test_abort();
        run_sweep(16'd2, 32'd100, 32'd10, 16'd1, 2, -1, -1, 6, 1'b0);
        n_checks++;
        if (!aborted || port_sel !== 4'd3 || done_cnt !== 0) begin
            n_fail++;
            $display("FAIL abort_setup: got aborted=%0b port_sel=%0d done=%0d, expected 1 3 0",
                     aborted, port_sel, done_cnt);
        end
        tick();
        abort = 1'b0;
        n_checks++;
        if ({f_word, port_sel, src_en, meas_req, rec_valid, rec_data, rec_point, rec_port,
             rec_err, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL abort_idle: got busy=%0b src_en=%0b meas_req=%0b port_sel=%0d, expected all zero",
                     busy, src_en, meas_req, port_sel);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet[%0d]: got done=%0b busy=%0b, expected 0 0", i, done, busy);
            end
        end
        run_sweep(16'd1, 32'd300, 32'd10, 16'd1, 0, -1, -1, -1, 1'b0);
        n_checks++;
        if (rec_cnt !== 4 || log_port[0] !== 4'd1 || log_point[0] !== 16'd0 ||
            log_fword[0] !== 32'd300 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL abort_restart: got %0d records first port=%0d point=%0d fword=%0d, expected 4 1 0 300",
                     rec_cnt, log_port[0], log_point[0], log_fword[0]);
        end
    endtask

    task automatic test_edges();
        run_sweep(16'd0, 32'd5, 32'd5, 16'd3, 0, -1, -1, -1, 1'b0);
        n_checks++;
        if (rec_cnt !== 0 || first_req_cyc !== -1 || done_cyc !== 0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL zero_points: got %0d records, req at %0d, done at %0d x%0d, expected 0 -1 0 x1",
                     rec_cnt, first_req_cyc, done_cyc, done_cnt);
        end
        n_checks++;
        if (post_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_idle: got busy=%0b, expected 0", post_busy);
        end
        run_sweep(16'd2, 32'hFFFF_FF00, 32'h0000_0200, 16'd0, 0, -1, -1, -1, 1'b0);
        n_checks++;
        if (log_fword[3] !== 32'hFFFF_FF00 || log_fword[4] !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL fword_wrap: got %0h then %0h, expected ffffff00 then 00000100",
                     log_fword[3], log_fword[4]);
        end
        run_sweep(16'd2, 32'd7, 32'd3, 16'd1, 1, -1, -1, -1, 1'b1);
        n_checks++;
        if (timed_out || rec_cnt !== 8 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL start_busy: got %0d records, done x%0d, timeout=%0b, expected 8 x1 0",
                     rec_cnt, done_cnt, timed_out);
        end
        n_checks++;
        if (log_port[7] !== 4'd4 || log_point[7] !== 16'd1 || log_fword[7] !== 32'd10) begin
            n_fail++;
            $display("FAIL start_busy_last: got port=%0d point=%0d fword=%0d, expected 4 1 10",
                     log_port[7], log_point[7], log_fword[7]);
        end
    endtask

    task automatic test_reset_mid();
        f_start = 32'h1234; f_step = 32'd1; n_points = 16'd3; settle_cycles = 16'd2;
        rec_ready = 1'b1; meas_ack = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b1 || src_en !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_setup: got busy=%0b src_en=%0b, expected 1 1", busy, src_en);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({f_word, port_sel, src_en, meas_req, rec_valid, rec_data, rec_point, rec_port,
             rec_err, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%0b port_sel=%0d f_word=%0h, expected all zero",
                     busy, port_sel, f_word);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

`ifdef SWEEP_TIMEOUT_EN
    task automatic test_timeout();
        run_sweep(16'd2, 32'd1000, 32'd500, 16'd1, 1, -1, 1, -1, 1'b0);
        n_checks++;
        if (timed_out || rec_cnt !== 8 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL timeout_count: got %0d records done x%0d, expected 8 x1", rec_cnt, done_cnt);
        end
        n_checks++;
        if (log_err[1] !== 1'b1 || log_data[1] !== 32'd0 || log_port[1] !== 4'd2 || log_point[1] !== 16'd0) begin
            n_fail++;
            $display("FAIL timeout_record: got err=%0b data=%0h port=%0d point=%0d, expected 1 0 2 0",
                     log_err[1], log_data[1], log_port[1], log_point[1]);
        end
        n_checks++;
        if (log_req_len[1] !== 16) begin
            n_fail++;
            $display("FAIL timeout_len: got %0d req cycles, expected 16", log_req_len[1]);
        end
        n_checks++;
        if (log_err[2] !== 1'b0 || log_data[2] !== 32'hD000_0002) begin
            n_fail++;
            $display("FAIL timeout_clear: got err=%0b data=%0h, expected 0 d0000002", log_err[2], log_data[2]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_settle();
        test_backpressure();
        test_abort();
        test_edges();
        test_reset_mid();
`ifdef SWEEP_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sparam_sweep_ctrl.md
Name: sparam_sweep_ctrl

Overview:
Frequency/port sweep sequencer that sits directly upstream of the S-parameter measurement stage for the 4-port microstrip coupler bench.
- For each frequency point, excites ports 1..NPORTS in turn and drives the source frequency word and enable.
- Waits a programmable settle time, then requests and captures one measurement.
- Emits one tagged record per (point, port) on a valid/ready stream consumed by the S-matrix/equation stage.

Parameters:
- NPORTS, 4, number of excitation ports (2..15)
- FW, 32, frequency word width
- PW, 16, point-index width
- DW, 32, measurement data width
- SW, 16, settle counter width
- TIMEOUT, 1024, measurement timeout in cycles (used only with the optional feature)

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle sweep start; sampled in IDLE only
- abort  in  1  return to IDLE next cycle from any state
- f_start  in  FW  first frequency word
- f_step  in  FW  frequency increment per point
- n_points  in  PW  number of frequency points
- settle_cycles  in  SW  wait cycles after each source change
- f_word  out  FW  current source frequency
- port_sel  out  4  excited port, 1..NPORTS; 0 when idle
- src_en  out  1  source enable
- meas_req  out  1  measurement request
- meas_ack  in  1  measurement accepted; meas_data valid in the same cycle
- meas_data  in  DW  measured value
- rec_valid  out  1  record valid
- rec_ready  in  1  downstream ready
- rec_data  out  DW  captured measurement
- rec_point  out  PW  point index of the record
- rec_port  out  4  port of the record
- rec_err  out  1  record flagged as timed out
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at sweep end

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- States: IDLE, SETTLE, MEASURE, EMIT, DONE.
- IDLE, start=1, n_points>0:
  - Latch f_step and n_points.
  - f_word<=f_start, port_sel<=1, point<=0, settle counter<=settle_cycles.
  - Go to SETTLE.
- IDLE, start=1, n_points=0: go to DONE; no records are emitted.
- start while busy: ignored.
- SETTLE:
  - src_en=1.
  - Counter==0 goes to MEASURE; otherwise the counter decrements.
  - Result: meas_req first rises settle_cycles+1 cycles after the start edge.
- MEASURE:
  - meas_req=1, held until meas_ack.
  - On meas_ack, rec_data<=meas_data and go to EMIT. meas_req drops the following cycle.
- EMIT:
  - rec_valid=1. rec_data, rec_point and rec_port stay stable until the handshake (rec_valid & rec_ready).
  - On handshake, if port_sel<NPORTS: port_sel++, reload the settle counter, go to SETTLE.
  - On handshake at port_sel==NPORTS and point==n_points-1: go to DONE.
  - Otherwise: port_sel<=1, point++, f_word<=f_word+f_step (modulo 2^FW, wrap silent), reload the settle counter, go to SETTLE.
- DONE: done=1 for one cycle, src_en=0, then IDLE with port_sel=0.
- abort: has priority over every transition; next cycle state=IDLE and src_en, meas_req, rec_valid=0. Any pending record is discarded; done is not pulsed.
- src_en: stays high through SETTLE/MEASURE/EMIT for the whole sweep.
- Total records: n_points*NPORTS, in point-major, port-minor order.
- Reset mid-sweep: immediate return to the reset values, asynchronously.

Optional Feature:
- Macro: SWEEP_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in MEASURE.
  - If meas_ack is absent for TIMEOUT cycles, go to EMIT with rec_data=0 and rec_err=1; the sweep continues.
  - rec_err clears on the next record.
- Undefined: rec_err is tied 0 and MEASURE waits indefinitely.

Test Plan:
1. Basic sweep: n_points=2, f_start=1000, f_step=500, settle_cycles=3, meas_ack 2 cycles after each req, rec_ready=1 -> 8 records.
   - Ports 1,2,3,4,1,2,3,4; points 0,0,0,0,1,1,1,1.
   - f_word 1000 then 1500.
   - done one cycle after the 8th handshake.
2. Settle timing: settle_cycles=0 -> meas_req high exactly 1 cycle after start; settle_cycles=5 -> 6 cycles after start.
3. Backpressure: rec_ready low 10 cycles during a record -> rec_valid and the record fields are held stable; no meas_req until the handshake.
4. Abort and restart: abort during MEASURE of point 1, port 3 -> IDLE next cycle, all outputs 0, no done pulse; a new start restarts at point 0, port 1.
5. Edge cases: n_points=0 -> done pulse the cycle after start, zero records. f_start=0xFFFFFF00, f_step=0x200 -> second-point f_word=0x00000100. start asserted while busy -> no effect.
6. SWEEP_TIMEOUT_EN, TIMEOUT=16, no meas_ack for point 0, port 2 -> record with rec_err=1 and rec_data=0 after 16 cycles; the sweep completes with 8 records.
